button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
//
// PURPOSE
//   Conditions raw, asynchronous board push-button levels before they drive the
//   SoC's reset and halt inputs at the board top level.
//   Each channel has a 2-flop synchronizer and a per-channel stability counter.
//   The debounced level changes only after the synchronized input has held a new
//   value for DEBOUNCE_CYCLES consecutive clocks.
//   One-cycle rise and fall strobes are also provided for software-visible events.
//
// PARAMETERS
//   NUM_BUTTONS      2     number of independent button channels (>=1)
//   DEBOUNCE_CYCLES  120000  consecutive stable clocks required to accept a change
//                          (>=1; 120000 = 10 ms at 12 MHz)
//   RESET_LEVEL      0     per-channel level ({NUM_BUTTONS} replicated bit) loaded
//                          into synchronizers and outputs during reset
//
// PORTS
//   clock        input   1            system clock; all flops on posedge
//   reset        input   1            asynchronous, active-high reset
//   button_in    input   NUM_BUTTONS  raw pad levels, asynchronous to clock
//   button_out   output  NUM_BUTTONS  debounced, clock-synchronous levels
//   button_rise  output  NUM_BUTTONS  1-cycle strobe: button_out went 0->1
//   button_fall  output  NUM_BUTTONS  1-cycle strobe: button_out went 1->0
//
// BEHAVIOUR
//   - Reset (async assert, any time, including mid-count):
//     - sync1, sync2 and button_out = RESET_LEVEL.
//     - All counters = 0.
//     - button_rise and button_fall = 0.
//     - No strobe is generated on reset entry or exit.
//   - Synchronizer: sync1 <= button_in; sync2 <= sync1.
//     No logic may read sync1 or button_in directly.
//   - Counter width: $clog2(DEBOUNCE_CYCLES+1). It is unsigned and never wraps.
//   - Per channel, at each posedge:
//     - If sync2 == button_out: count <= 0.
//     - If sync2 != button_out and count < DEBOUNCE_CYCLES-1: count <= count+1.
//     - If sync2 != button_out and count == DEBOUNCE_CYCLES-1:
//       - button_out <= sync2 and count <= 0.
//       - The matching rise or fall strobe is asserted for exactly this one cycle.
//   - Latency: let edge k be the first posedge that samples a new button_in level.
//     That level is in sync2 after edge k+1, and button_out changes at edge
//     k+1+DEBOUNCE_CYCLES, provided the level holds throughout.
//   - Any return of sync2 to button_out before acceptance clears the count.
//     Bounces therefore restart the full window, and no partial credit is kept.
//   - A strobe is high in the same cycle that button_out first shows the new level.
//     rise and fall are never both high on one channel.
//   - Channels are fully independent. Simultaneous changes on several channels
//     produce simultaneous, independent strobes.
//   - DEBOUNCE_CYCLES=1: button_out follows sync2 with one clock of delay.
//   - Outputs are registered with no combinational path from button_in.
//
// TESTING  (NUM_BUTTONS=2, DEBOUNCE_CYCLES=8, RESET_LEVEL=0 unless noted)
//   1. Assert reset with button_in=2'b11, then release -> button_out=00 and no
//      strobes at release. button_out=11 appears 9 edges after first sampling;
//      button_rise=11 for 1 cycle.
//   2. Clean press on ch0, held 20 cycles -> button_out[0] rises at edge k+9 and
//      button_rise[0] pulses once. ch1 is unchanged.
//   3. ch0 toggles every 3 cycles for 30 cycles, then holds 1 -> no output change
//      during the bounce; a single rise 9 edges after the final transition.
//   4. Output high, then a 5-cycle low glitch -> no fall. A 12-cycle low pulse ->
//      exactly one fall, then one rise after the input returns high.
//   5. Reset asserted asynchronously (between edges) when the ch0 count is 5 ->
//      button_out stays 0 and no strobe occurs. After release the full 8-cycle
//      window is required again.
//   6. RESET_LEVEL=1 with DEBOUNCE_CYCLES=1 -> reset drives outputs to 11.
//      Releasing a button gives a fall 2 edges after sampling.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel 2-flop synchronizer, stability counter,
// debounced level output and one-cycle rise/fall strobes. Every output is a
// flop, so nothing combinational reaches the outputs from the pads.
module button_debouncer #(
    parameter int   NUM_BUTTONS     = 2,
    parameter int   DEBOUNCE_CYCLES = 120000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_in,
    output logic [NUM_BUTTONS-1:0] button_out,
    output logic [NUM_BUTTONS-1:0] button_rise,
    output logic [NUM_BUTTONS-1:0] button_fall
);

    // Counter just wide enough for DEBOUNCE_CYCLES; it saturates at the
    // acceptance point and is cleared there, so it never wraps.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_out;
            logic             r_rise;
            logic             r_fall;
            logic [CNT_W-1:0] r_count;
            logic             w_differs;
            logic             w_accept;
            logic [CNT_W-1:0] w_count_next;

            // Stability tracking: any agreement between the synchronized pad
            // and the output discards partial credit; acceptance happens on the
            // last cycle of an unbroken disagreement window.
            always_comb begin
                w_differs    = (r_sync2 != r_out);
                w_accept     = w_differs && (r_count == CNT_LAST);
                w_count_next = '0;
                if (w_differs && !w_accept) begin
                    w_count_next = r_count + CNT_ONE;
                end
            end

            // Synchronizer, counter, debounced level and strobes; reset puts
            // everything in the idle state so neither edge of reset strobes.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_sync1 <= RESET_LEVEL;
                    r_sync2 <= RESET_LEVEL;
                    r_out   <= RESET_LEVEL;
                    r_count <= '0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_sync1 <= button_in[gi];
                    r_sync2 <= r_sync1;
                    r_count <= w_count_next;
                    r_rise  <= w_accept && r_sync2;
                    r_fall  <= w_accept && !r_sync2;
                    if (w_accept) begin
                        r_out <= r_sync2;
                    end
                end
            end

            assign button_out[gi]  = r_out;
            assign button_rise[gi] = r_rise;
            assign button_fall[gi] = r_fall;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: instance A (8-cycle window, reset level 0) and instance B
// (1-cycle window, reset level 1) share clock and reset.
module tb_button_debouncer;

    logic       clock;
    logic       reset;
    logic [1:0] bin_a;
    logic [1:0] out_a, rise_a, fall_a;
    logic [1:0] bin_b;
    logic [1:0] out_b, rise_b, fall_b;

    int errors = 0;
    int checks = 0;

    button_debouncer #(
        .NUM_BUTTONS    (2),
        .DEBOUNCE_CYCLES(8),
        .RESET_LEVEL    (1'b0)
    ) dut_a (
        .clock      (clock),
        .reset      (reset),
        .button_in  (bin_a),
        .button_out (out_a),
        .button_rise(rise_a),
        .button_fall(fall_a)
    );

    button_debouncer #(
        .NUM_BUTTONS    (2),
        .DEBOUNCE_CYCLES(1),
        .RESET_LEVEL    (1'b1)
    ) dut_b (
        .clock      (clock),
        .reset      (reset),
        .button_in  (bin_b),
        .button_out (out_b),
        .button_rise(rise_b),
        .button_fall(fall_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n active edges; leave time 1 unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // ---- Test 1: reset with buttons held, then release ----
        reset = 1'b1;
        bin_a = 2'b11;
        bin_b = 2'b11;
        tick(3);
        chk("t1_rst_out_a", out_a, 2'b00);
        chk("t1_rst_rise_a", rise_a, 2'b00);
        chk("t1_rst_out_b", out_b, 2'b11);
        reset = 1'b0;
        tick(9);
        chk("t1_out_before", out_a, 2'b00);
        chk("t1_rise_before", rise_a, 2'b00);
        chk("t1_fall_b_quiet", fall_b, 2'b00);
        tick(1);
        chk("t1_out_accept", out_a, 2'b11);
        chk("t1_rise_accept", rise_a, 2'b11);
        tick(1);
        chk("t1_rise_clear", rise_a, 2'b00);
        chk("t1_out_hold", out_a, 2'b11);

        // ---- Bring both channels back low ----
        bin_a = 2'b00;
        tick(10);
        chk("t2_pre_fall", fall_a, 2'b11);
        chk("t2_pre_out", out_a, 2'b00);
        tick(1);

        // ---- Test 2: clean press on ch0 ----
        bin_a = 2'b01;
        tick(9);
        chk("t2_out_before", out_a, 2'b00);
        tick(1);
        chk("t2_out_accept", out_a, 2'b01);
        chk("t2_rise", rise_a, 2'b01);
        tick(1);
        chk("t2_rise_clear", rise_a, 2'b00);
        tick(9);
        chk("t2_out_held", out_a, 2'b01);
        chk("t2_no_strobe", rise_a | fall_a, 2'b00);

        // ---- Test 3: bounce on ch0 then settle high ----
        bin_a = 2'b00;
        tick(10);
        chk("t3_pre_fall", fall_a, 2'b01);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            bin_a[0] = ~bin_a[0];
            for (int j = 0; j < 3; j++) begin
                tick(1);
                chk("t3_bounce_out", out_a, 2'b00);
                chk("t3_bounce_rise", rise_a, 2'b00);
            end
        end
        bin_a = 2'b01;
        tick(9);
        chk("t3_out_before", out_a, 2'b00);
        tick(1);
        chk("t3_out_accept", out_a, 2'b01);
        chk("t3_rise", rise_a, 2'b01);
        tick(1);
        chk("t3_rise_clear", rise_a, 2'b00);

        // ---- Test 4: short glitch ignored, long pulse accepted ----
        bin_a = 2'b00;
        for (int j = 0; j < 5; j++) begin
            tick(1);
            chk("t4_glitch_fall", fall_a, 2'b00);
        end
        bin_a = 2'b01;
        for (int j = 0; j < 12; j++) begin
            tick(1);
            chk("t4_glitch_out", out_a, 2'b01);
            chk("t4_glitch_fall2", fall_a, 2'b00);
        end
        bin_a = 2'b00;
        tick(9);
        chk("t4_pulse_before", out_a, 2'b01);
        tick(1);
        chk("t4_pulse_out", out_a, 2'b00);
        chk("t4_pulse_fall", fall_a, 2'b01);
        tick(1);
        chk("t4_fall_clear", fall_a, 2'b00);
        tick(1);
        bin_a = 2'b01;
        tick(9);
        chk("t4_ret_before", out_a, 2'b00);
        tick(1);
        chk("t4_ret_out", out_a, 2'b01);
        chk("t4_ret_rise", rise_a, 2'b01);

        // ---- Test 5: async reset mid-count restarts the window ----
        bin_a = 2'b00;
        tick(10);
        chk("t5_pre_fall", fall_a, 2'b01);
        tick(1);
        bin_a = 2'b01;
        tick(7);
        chk("t5_midcount_out", out_a, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_out", out_a, 2'b00);
        chk("t5_async_rise", rise_a, 2'b00);
        tick(2);
        chk("t5_hold_out", out_a, 2'b00);
        chk("t5_hold_rise", rise_a, 2'b00);
        chk("t5_out_b_reset", out_b, 2'b11);
        reset = 1'b0;
        tick(9);
        chk("t5_out_before", out_a, 2'b00);
        chk("t5_rise_before", rise_a, 2'b00);
        tick(1);
        chk("t5_out_accept", out_a, 2'b01);
        chk("t5_rise", rise_a, 2'b01);

        // ---- Test 6: one-cycle window, reset level high ----
        chk("t6_out_b_idle", out_b, 2'b11);
        bin_b = 2'b10;
        tick(2);
        chk("t6_out_before", out_b, 2'b11);
        chk("t6_fall_before", fall_b, 2'b00);
        tick(1);
        chk("t6_out_accept", out_b, 2'b10);
        chk("t6_fall", fall_b, 2'b01);
        chk("t6_no_rise", rise_b, 2'b00);
        tick(1);
        chk("t6_fall_clear", fall_b, 2'b00);
        bin_b = 2'b11;
        tick(2);
        chk("t6_ret_before", out_b, 2'b10);
        tick(1);
        chk("t6_ret_out", out_b, 2'b11);
        chk("t6_ret_rise", rise_b, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
